// File: rtl/simple_axi_to_axi_read.sv
// simple_axi_to_axi_read
// AXI4 read master: turns one simple-bus read request (byte address, byte
// length) into a sequence of INCR bursts and streams the returned words back
// with a last flag on the final word of the whole request. Bursts never exceed
// 256 beats nor cross a 4 KiB boundary, and only one burst is outstanding.

module simple_axi_to_axi_read #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1,
  parameter int LEN_W      = 20
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  // simple read bus
  input  logic                  m_rvalid_i,
  input  logic [AXI_ADDR_W-1:0] m_raddr_i,
  input  logic [LEN_W-1:0]      m_rlen_i,
  output logic                  m_rready_o,
  output logic [AXI_DATA_W-1:0] m_rdata_o,
  output logic                  m_rlast_o,
  output logic                  m_rerror_o,

  // AXI read address channel
  output logic [AXI_ID_W-1:0]   axi_arid_o,
  output logic [AXI_ADDR_W-1:0] axi_araddr_o,
  output logic [AXI_LEN_W-1:0]  axi_arlen_o,
  output logic [2:0]            axi_arsize_o,
  output logic [1:0]            axi_arburst_o,
  output logic [1:0]            axi_arlock_o,
  output logic [3:0]            axi_arcache_o,
  output logic [2:0]            axi_arprot_o,
  output logic [3:0]            axi_arqos_o,
  output logic                  axi_arvalid_o,
  input  logic                  axi_arready_i,

  // AXI read data channel
  input  logic [AXI_ID_W-1:0]   axi_rid_i,
  input  logic [AXI_DATA_W-1:0] axi_rdata_i,
  input  logic [1:0]            axi_rresp_i,
  input  logic                  axi_rlast_i,
  input  logic                  axi_rvalid_i,
  output logic                  axi_rready_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_GAP  = 3'd4,
    S_ZERO = 3'd5
  } state_t;

  localparam logic [LEN_W-1:0] MAX_BURST = LEN_W'(1 << AXI_LEN_W);

  state_t                state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      rem_bytes_q, rem_bytes_d;
  logic [AXI_LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [AXI_LEN_W-1:0]  arlen_q, arlen_d;
  logic [AXI_ADDR_W-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rerror_q, rerror_d;

  // burst sizing, derived from the current address and remaining byte count
  logic [LEN_W-1:0]      rem_words;
  logic [LEN_W-1:0]      to4k;
  logic [LEN_W-1:0]      beats;
  logic [LEN_W-1:0]      burst_bytes;
  logic [LEN_W-1:0]      consumed;

  logic                  unused_inputs;
  assign unused_inputs = ^{axi_rid_i, axi_rlast_i, m_raddr_i[1:0]};

  // Burst size: min(words left, max burst, words to next 4 KiB page).
  always_comb begin
    rem_words   = ((rem_bytes_q - LEN_W'(1)) >> 2) + LEN_W'(1);
    to4k        = LEN_W'((13'd4096 - {1'b0, addr_q[11:0]}) >> 2);
    beats       = rem_words;
    if (MAX_BURST < beats) beats = MAX_BURST;
    if (to4k < beats)      beats = to4k;
    burst_bytes = {beats[LEN_W-3:0], 2'b00};
    consumed    = (burst_bytes < rem_bytes_q) ? burst_bytes : rem_bytes_q;
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_bytes_q <= '0;
      beat_cnt_q  <= '0;
      arlen_q     <= '0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rerror_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_bytes_q <= rem_bytes_d;
      beat_cnt_q  <= beat_cnt_d;
      arlen_q     <= arlen_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rerror_q    <= rerror_d;
    end
  end

  // Next-state logic: request latch, burst issue, beat counting.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_bytes_d = rem_bytes_q;
    beat_cnt_d  = beat_cnt_q;
    arlen_d     = arlen_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rerror_d    = rerror_q;
    case (state_q)
      S_IDLE: begin
        if (m_rvalid_i) begin
          addr_d      = {m_raddr_i[AXI_ADDR_W-1:2], 2'b00};
          rem_bytes_d = m_rlen_i;
          rerror_d    = 1'b0;
          state_d     = (m_rlen_i == '0) ? S_ZERO : S_CALC;
        end
      end
      S_CALC: begin
        arlen_d   = AXI_LEN_W'(beats - LEN_W'(1));
        araddr_d  = addr_q;
        arvalid_d = 1'b1;
        state_d   = S_ADDR;
      end
      S_ADDR: begin
        // Address and remaining length advance on acceptance, so the last
        // beat of the request can be recognised by rem_bytes being zero.
        if (axi_arready_i) begin
          arvalid_d   = 1'b0;
          beat_cnt_d  = '0;
          addr_d      = addr_q + AXI_ADDR_W'(consumed);
          rem_bytes_d = rem_bytes_q - consumed;
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (axi_rvalid_i) begin
          beat_cnt_d = beat_cnt_q + AXI_LEN_W'(1);
          if (axi_rresp_i != 2'b00) rerror_d = 1'b1;
          if (beat_cnt_q == arlen_q) state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = (rem_bytes_q == '0) ? S_IDLE : S_CALC;
      end
      S_ZERO: begin
        state_d = S_GAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Simple-bus outputs: data passes straight through while in the data phase.
  always_comb begin
    m_rready_o   = 1'b0;
    m_rdata_o    = '0;
    m_rlast_o    = 1'b0;
    axi_rready_o = 1'b0;
    case (state_q)
      S_DATA: begin
        axi_rready_o = 1'b1;
        m_rready_o   = axi_rvalid_i;
        m_rdata_o    = axi_rdata_i;
        m_rlast_o    = axi_rvalid_i && (beat_cnt_q == arlen_q) && (rem_bytes_q == '0);
      end
      S_ZERO: begin
        m_rlast_o = 1'b1;
      end
      default: begin
        m_rlast_o = 1'b0;
      end
    endcase
  end

  assign m_rerror_o    = rerror_q;
  assign axi_arid_o    = '0;
  assign axi_araddr_o  = araddr_q;
  assign axi_arlen_o   = arlen_q;
  assign axi_arsize_o  = 3'b010;
  assign axi_arburst_o = 2'b01;
  assign axi_arlock_o  = '0;
  assign axi_arcache_o = '0;
  assign axi_arprot_o  = '0;
  assign axi_arqos_o   = '0;
  assign axi_arvalid_o = arvalid_q;

endmodule

// File: tb/tb_simple_axi_to_axi_read.sv
// tb_simple_axi_to_axi_read
// Randomised requests against a behavioural AXI slave; expected bursts and
// word stream come from a request-level model, checked every cycle.

module tb_simple_axi_to_axi_read;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LW   = 8;
  localparam int IW   = 1;
  localparam int LENW = 20;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            m_rvalid_i;
  logic [AW-1:0]   m_raddr_i;
  logic [LENW-1:0] m_rlen_i;
  logic            m_rready_o;
  logic [DW-1:0]   m_rdata_o;
  logic            m_rlast_o;
  logic            m_rerror_o;
  logic [IW-1:0]   axi_arid_o;
  logic [AW-1:0]   axi_araddr_o;
  logic [LW-1:0]   axi_arlen_o;
  logic [2:0]      axi_arsize_o;
  logic [1:0]      axi_arburst_o;
  logic [1:0]      axi_arlock_o;
  logic [3:0]      axi_arcache_o;
  logic [2:0]      axi_arprot_o;
  logic [3:0]      axi_arqos_o;
  logic            axi_arvalid_o;
  logic            axi_arready_i;
  logic [IW-1:0]   axi_rid_i;
  logic [DW-1:0]   axi_rdata_i;
  logic [1:0]      axi_rresp_i;
  logic            axi_rlast_i;
  logic            axi_rvalid_i;
  logic            axi_rready_o;

  simple_axi_to_axi_read #(
    .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_LEN_W(LW), .AXI_ID_W(IW), .LEN_W(LENW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_rvalid_i(m_rvalid_i), .m_raddr_i(m_raddr_i), .m_rlen_i(m_rlen_i),
    .m_rready_o(m_rready_o), .m_rdata_o(m_rdata_o), .m_rlast_o(m_rlast_o),
    .m_rerror_o(m_rerror_o),
    .axi_arid_o(axi_arid_o), .axi_araddr_o(axi_araddr_o), .axi_arlen_o(axi_arlen_o),
    .axi_arsize_o(axi_arsize_o), .axi_arburst_o(axi_arburst_o),
    .axi_arlock_o(axi_arlock_o), .axi_arcache_o(axi_arcache_o),
    .axi_arprot_o(axi_arprot_o), .axi_arqos_o(axi_arqos_o),
    .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
    .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
    .axi_rlast_i(axi_rlast_i), .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // expected state of the current request
  logic [31:0] exp_q[$];       // word addresses still to be delivered
  logic [31:0] bur_addr_q[$];  // expected AR addresses
  logic [7:0]  bur_len_q[$];   // expected AR lengths
  bit          exp_zero = 1'b0;
  bit          err_seen = 1'b0;
  int          done_cnt = 0;
  int          beats_seen = 0;

  // slave configuration and state
  logic [31:0] sb_q[$];
  logic [31:0] err_addr = 32'h1;
  int          ar_delay = 0;
  int          rv_pct = 100;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event not expected at t=%0t", name, $time);
  endtask

  // Request-level model: contiguous word stream plus the burst split.
  task automatic build_model(input logic [31:0] addr, input int len);
    logic [31:0] a;
    int rem, words, to4k, b, cons;
    exp_q.delete();
    bur_addr_q.delete();
    bur_len_q.delete();
    a = {addr[31:2], 2'b00};
    for (int k = 0; k < (len + 3) / 4; k++) exp_q.push_back(a + 32'(4 * k));
    rem = len;
    while (rem > 0) begin
      words = (rem + 3) / 4;
      to4k  = (4096 - int'(a[11:0])) / 4;
      b = words;
      if (b > 256)  b = 256;
      if (b > to4k) b = to4k;
      bur_addr_q.push_back(a);
      bur_len_q.push_back(8'(b - 1));
      cons = (b * 4 < rem) ? b * 4 : rem;
      a   += 32'(cons);
      rem -= cons;
    end
    exp_zero = (len == 0);
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    m_rvalid_i = 1'b0;
    exp_q.delete();
    bur_addr_q.delete();
    bur_len_q.delete();
    exp_zero = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] addr, input int len, input int ard,
                        input int rvp, input logic [31:0] ea);
    int d0, c;
    bit ex_err;
    @(posedge clk_i); #1;
    build_model(addr, len);
    ex_err = 1'b0;
    foreach (exp_q[i]) if (exp_q[i] == ea) ex_err = 1'b1;
    err_addr = ea;
    ar_delay = ard;
    rv_pct = rvp;
    err_seen = 1'b0;
    d0 = done_cnt;
    m_rvalid_i = 1'b1;
    m_raddr_i = addr;
    m_rlen_i = LENW'(len);
    if (len != 0) begin
      @(posedge clk_i); #1;
      chk_eq("ar_latency_c1", 64'(axi_arvalid_o), 64'(0));
      @(posedge clk_i); #1;
      chk_eq("ar_latency_c2", 64'(axi_arvalid_o), 64'(1));
    end
    c = 0;
    while (done_cnt == d0 && c < 20000) begin
      @(posedge clk_i);
      c++;
    end
    #1;
    m_rvalid_i = 1'b0;
    if (done_cnt == d0) begin
      chk_eq("req_timeout", 64'(done_cnt - d0), 64'(1));
      apply_reset();
    end else begin
      chk_eq("rerror_end", 64'(m_rerror_o), 64'(ex_err));
      chk_eq("beats_left", 64'(exp_q.size()), 64'(0));
      chk_eq("bursts_left", 64'(bur_addr_q.size()), 64'(0));
    end
  endtask

  task automatic reset_test();
    int b0, c;
    @(posedge clk_i); #1;
    build_model(32'h200, 64);
    err_addr = 32'h1;
    ar_delay = 0;
    rv_pct = 100;
    err_seen = 1'b0;
    b0 = beats_seen;
    m_rvalid_i = 1'b1;
    m_raddr_i = 32'h200;
    m_rlen_i = LENW'(64);
    c = 0;
    while (beats_seen - b0 < 2 && c < 200) begin
      @(posedge clk_i);
      c++;
    end
    #3;
    chk_eq("rst_pre_beat3", 64'(m_rready_o), 64'(1));
    rst_i = 1'b1;
    #1;
    chk_eq("rst_m_rready", 64'(m_rready_o), 64'(0));
    chk_eq("rst_m_rlast", 64'(m_rlast_o), 64'(0));
    chk_eq("rst_m_rdata", 64'(m_rdata_o), 64'(0));
    chk_eq("rst_axi_rready", 64'(axi_rready_o), 64'(0));
    chk_eq("rst_arvalid", 64'(axi_arvalid_o), 64'(0));
    chk_eq("rst_araddr", 64'(axi_araddr_o), 64'(0));
    chk_eq("rst_arlen", 64'(axi_arlen_o), 64'(0));
    chk_eq("rst_rerror", 64'(m_rerror_o), 64'(0));
    apply_reset();
  endtask

  // Behavioural AXI slave: delayed arready, random rvalid, data from address.
  initial begin : slave
    bit hs_ar, hs_r;
    int wait_n;
    logic [31:0] ar_a;
    logic [7:0] ar_l;
    axi_arready_i = 1'b0;
    axi_rvalid_i = 1'b0;
    axi_rdata_i = '0;
    axi_rresp_i = 2'b00;
    axi_rlast_i = 1'b0;
    axi_rid_i = '0;
    wait_n = 0;
    forever begin
      @(negedge clk_i);
      hs_ar = !rst_i && axi_arvalid_o && axi_arready_i;
      hs_r  = !rst_i && axi_rvalid_i && axi_rready_o;
      ar_a  = axi_araddr_o;
      ar_l  = axi_arlen_o;
      if (!rst_i && axi_arvalid_o && !axi_arready_i) wait_n++;
      @(posedge clk_i); #1;
      if (rst_i) begin
        sb_q.delete();
        wait_n = 0;
        axi_arready_i = 1'b0;
        axi_rvalid_i = 1'b0;
        axi_rresp_i = 2'b00;
      end else begin
        if (hs_r) void'(sb_q.pop_front());
        if (hs_ar) begin
          for (int j = 0; j <= int'(ar_l); j++) sb_q.push_back(ar_a + 32'(4 * j));
          wait_n = 0;
        end
        axi_arready_i = axi_arvalid_o && (wait_n >= ar_delay);
        if (sb_q.size() == 0) axi_rvalid_i = 1'b0;
        else if (!(axi_rvalid_i && !hs_r)) axi_rvalid_i = ($urandom_range(0, 99) < rv_pct);
        if (sb_q.size() != 0) begin
          axi_rdata_i = memw(sb_q[0]);
          axi_rresp_i = (sb_q[0] == err_addr) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  // Per-cycle comparison against the request model.
  initial begin : compare
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        chk_eq("m_rready_vs_rvalid", 64'(m_rready_o), 64'(axi_rvalid_i));
        if (axi_rvalid_i) chk_eq("axi_rready", 64'(axi_rready_o), 64'(1));
        if (m_rready_o) begin
          if (exp_q.size() == 0) fail_now("unexpected_beat");
          else begin
            chk_eq("rerror_sticky", 64'(m_rerror_o), 64'(err_seen));
            chk_eq("rdata", 64'(m_rdata_o), 64'(memw(exp_q[0])));
            chk_eq("rlast", 64'(m_rlast_o), 64'(exp_q.size() == 1));
            if (exp_q[0] == err_addr) err_seen = 1'b1;
            if (exp_q.size() == 1) done_cnt++;
            void'(exp_q.pop_front());
            beats_seen++;
          end
        end else if (m_rlast_o) begin
          if (!exp_zero) fail_now("spurious_rlast");
          else begin
            chk_eq("zero_rdata", 64'(m_rdata_o), 64'(0));
            exp_zero = 1'b0;
            done_cnt++;
          end
        end
        if (axi_arvalid_o) begin
          if (bur_addr_q.size() == 0) fail_now("unexpected_ar");
          else begin
            chk_eq("ar_overlap", 64'(sb_q.size()), 64'(0));
            chk_eq("araddr", 64'(axi_araddr_o), 64'(bur_addr_q[0]));
            chk_eq("arlen", 64'(axi_arlen_o), 64'(bur_len_q[0]));
            if (axi_arready_i) begin
              void'(bur_addr_q.pop_front());
              void'(bur_len_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] a, ea;
    int len;
    rst_i = 1'b0;
    m_rvalid_i = 1'b0;
    m_raddr_i = '0;
    m_rlen_i = '0;
    #2 rst_i = 1'b1;
    #2;
    chk_eq("reset_arvalid", 64'(axi_arvalid_o), 64'(0));
    chk_eq("reset_araddr", 64'(axi_araddr_o), 64'(0));
    chk_eq("reset_arlen", 64'(axi_arlen_o), 64'(0));
    chk_eq("reset_rerror", 64'(m_rerror_o), 64'(0));
    chk_eq("reset_rlast", 64'(m_rlast_o), 64'(0));
    chk_eq("reset_rready", 64'(axi_rready_o), 64'(0));
    chk_eq("arsize", 64'(axi_arsize_o), 64'(2));
    chk_eq("arburst", 64'(axi_arburst_o), 64'(1));
    chk_eq("ar_ties", 64'({axi_arid_o, axi_arlock_o, axi_arcache_o, axi_arprot_o, axi_arqos_o}), 64'(0));
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;

    // hand-computed burst splits pinning the model
    build_model(32'h100, 16);
    chk_eq("pin_a_n", 64'(bur_addr_q.size()), 64'(1));
    chk_eq("pin_a_len", 64'(bur_len_q[0]), 64'(3));
    build_model(32'h0, 1030);
    chk_eq("pin_b_n", 64'(bur_addr_q.size()), 64'(2));
    chk_eq("pin_b_l0", 64'(bur_len_q[0]), 64'(255));
    chk_eq("pin_b_a1", 64'(bur_addr_q[1]), 64'(32'h400));
    chk_eq("pin_b_l1", 64'(bur_len_q[1]), 64'(1));
    chk_eq("pin_b_words", 64'(exp_q.size()), 64'(258));
    build_model(32'hFF8, 32);
    chk_eq("pin_c_l0", 64'(bur_len_q[0]), 64'(1));
    chk_eq("pin_c_a1", 64'(bur_addr_q[1]), 64'(32'h1000));
    chk_eq("pin_c_l1", 64'(bur_len_q[1]), 64'(5));
    exp_q.delete();
    bur_addr_q.delete();
    bur_len_q.delete();
    exp_zero = 1'b0;

    // directed scenarios
    do_req(32'h100, 16, 0, 100, 32'h1);
    do_req(32'h0, 1030, 0, 100, 32'h1);
    do_req(32'hFF8, 32, 0, 100, 32'h1);
    do_req(32'h123, 0, 0, 100, 32'h1);
    do_req(32'h300, 8, 5, 50, 32'h304);
    repeat (3) begin
      @(posedge clk_i); #1;
      chk_eq("rerror_hold", 64'(m_rerror_o), 64'(1));
    end
    do_req(32'h500, 12, 0, 100, 32'h1);
    reset_test();
    do_req(32'h40, 4, 0, 100, 32'h1);

    // randomised requests, some straddling 4 KiB pages or with error beats
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 2) == 0)
        a = 32'h1000 * $urandom_range(1, 14) - 32'($urandom_range(0, 64));
      else
        a = 32'($urandom_range(0, 32'hEFFF));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(1, 600);
      ea = 32'h1;
      if (len > 0 && $urandom_range(0, 2) == 0)
        ea = {a[31:2], 2'b00} + 32'(4 * $urandom_range(0, (len + 3) / 4 - 1));
      do_req(a, len, $urandom_range(0, 3), $urandom_range(30, 100), ea);
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
    end

    repeat (4) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/simple_axi_to_axi_read.md
Name: simple_axi_to_axi_read

Overview:
AXI4 read master that converts a single simple-bus read request (address, byte length) into one or more INCR read bursts. Read data is returned on the simple bus as a word stream, with a last flag on the final word. It is the read-direction companion to the simple-to-AXI write bridge and sits between Versat read units and the AXI interconnect.

Parameters:
AXI_ADDR_W, 32, address width (simple and AXI).
AXI_DATA_W, 32, data width; only 32 is supported (arsize fixed to 3'b010).
AXI_LEN_W, 8, arlen width.
AXI_ID_W, 1, arid/rid width.
LEN_W, 20, width of the simple-bus byte length.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset: asynchronous, active-high
m_rvalid_i  in  1  request valid; held high until the cycle after m_rlast_o
m_raddr_i  in  AXI_ADDR_W  start byte address; bits [1:0] ignored (forced 0)
m_rlen_i  in  LEN_W  request length in bytes
m_rready_o  out  1  data beat valid on m_rdata_o; consumer must accept every beat
m_rdata_o  out  AXI_DATA_W  read data
m_rlast_o  out  1  final beat of the whole request (or completion strobe when length is 0)
m_rerror_o  out  1  sticky: any beat in the current request returned rresp != OKAY
axi_arid_o  out  AXI_ID_W  tied 0
axi_araddr_o  out  AXI_ADDR_W  burst address (registered)
axi_arlen_o  out  AXI_LEN_W  beats-1 (registered)
axi_arsize_o  out  3  3'b010
axi_arburst_o  out  2  2'b01 INCR
axi_arlock_o  out  2  tied 0
axi_arcache_o  out  4  tied 0
axi_arprot_o  out  3  tied 0
axi_arqos_o  out  4  tied 0
axi_arvalid_o  out  1  address valid (registered)
axi_arready_i  in  1  address ready
axi_rid_i  in  AXI_ID_W  ignored
axi_rdata_i  in  AXI_DATA_W  read data
axi_rresp_i  in  2  read response
axi_rlast_i  in  1  burst last (ignored; the internal beat counter is authoritative)
axi_rvalid_i  in  1  data valid
axi_rready_o  out  1  data ready

Behaviour:
- Reset values: all registered outputs 0; state IDLE; m_rerror_o 0. Reset mid-burst aborts immediately, with no drain of the outstanding burst.
- Internal registers: addr (word aligned), rem_bytes (LEN_W), rem_words, beat_cnt (AXI_LEN_W).
- Word count: words = ((rem_bytes-1)>>2)+1.
- 4 KiB boundary: to4k = (4096 - addr[11:0])>>2, giving 1..1024.
- Beats per burst: beats = min(words, 256, to4k).
- Bytes consumed per burst: consumed = min(beats*4, rem_bytes).
- States:
  - IDLE(0): on m_rvalid_i, latch addr = {m_raddr_i[hi:2],2'b00}, rem_bytes = m_rlen_i, clear m_rerror_o. Go to CALC, or to ZERO if m_rlen_i == 0.
  - CALC(1): register arlen = beats-1, araddr = addr; set arvalid. Go to ADDR.
  - ADDR(2): when axi_arready_i is high: clear arvalid; beat_cnt = 0; addr += consumed; rem_bytes -= consumed. Go to DATA.
  - DATA(3): axi_rready_o = 1. m_rready_o = axi_rvalid_i and m_rdata_o = axi_rdata_i, both combinational. On each handshake, beat_cnt++ and m_rerror_o |= (axi_rresp_i != 0). On the handshake where beat_cnt == arlen, go to GAP. On that same beat, m_rlast_o = 1 iff rem_bytes == 0.
  - GAP(4): one idle cycle for interconnect master switching. If rem_bytes == 0 go to IDLE, else go to CALC.
  - ZERO(5): m_rlast_o = 1 for one cycle with m_rready_o = 0 and m_rdata_o = 0. Go to GAP.
  - Any other encoding goes to IDLE.
- Outside DATA: axi_rready_o = 0 and m_rready_o = 0. m_rlast_o is 0 except as stated above.
- Partial final word (length not a multiple of 4): a full word is returned; bytes beyond the length are don't-care.
- Only one burst is outstanding at a time; no overlap of AR and R phases across bursts.
- A request is accepted only in IDLE. m_rvalid_i changes outside IDLE are ignored until the FSM returns to IDLE. GAP guarantees at least 1 cycle after m_rlast_o before the next request is sampled.
- Latency: first arvalid occurs 2 cycles after m_rvalid_i is sampled in IDLE.
- m_rerror_o holds until the next accepted request.

Test Plan:
- Addr 0x100, len 16, slave with 0-wait and arready=1 → one AR (araddr 0x100, arlen 3); 4 beats passed through; m_rlast_o on beat 4; m_rerror_o 0.
- Addr 0x0, len 1030 → AR0 0x0 arlen 255, then GAP, then AR1 0x400 arlen 1; 258 beats total; m_rlast_o only on beat 258.
- Addr 0xFF8, len 32 (4 KiB crossing) → AR0 0xFF8 arlen 1, AR1 0x1000 arlen 5; m_rlast_o on beat 8.
- Len 0 → no arvalid ever; single m_rlast_o pulse with m_rready_o 0; FSM returns to IDLE after GAP.
- Len 8, axi_rvalid_i toggled randomly, axi_arready_i delayed 5 cycles, beat 2 rresp = 2'b10 → arvalid held until arready; data order preserved; m_rerror_o = 1 after beat 2 and stays 1 until the next request.
- rst_i asserted during beat 3 of a 16-beat burst → all outputs 0 asynchronously. A new request (addr 0x40, len 4) then completes normally.
